exec_pipe: RTL
==============

// Module: exec_pipe
// PURPOSE
//  Parametrised execute stage of the ARM-subset core: register file, ALU, NZCV flags and conditional branch resolution.
//  Sits between decode and fetch. Consumes one decoded uop per accepted beat.
//  Returns a PC delta plus a flush window (global_disable) to fetch/decode.
//  Adds over the previous stage: in_valid/in_ready handshake, a flags register, ARM condition evaluation and an optional iterative MUL.
// PARAMETERS
//  DW            32  datapath / register width in bits (>=8)
//  NREGS         16  number of GPRs (power of 2); RW = $clog2(NREGS)
//  FLUSH_CYCLES  2   cycles global_disable stays high after a taken branch (>=1)
// PORTS
//  clk                input   1     clock, all state on rising edge
//  rst_n              input   1     asynchronous active-low reset
//  in_valid           input   1     decode presents a uop
//  in_ready           output  1     stage accepts the uop this cycle
//  uop                input   5     0 NOP,1 ADD,2 SUB,3 AND,4 ORR,5 CMP,6 EOR,7 B,8 MOV,9 MUL
//  num_to_rhs         input   1     1: rhs=num, 0: rhs=R[sel_p1]
//  num                input   DW    immediate / branch offset
//  sel_p0,sel_p1      input   RW    source register selects
//  sel_in             input   RW    destination register select
//  branch_cond        input   4     ARM cond code for B; 4'b1111 treated as AL
//  delta_instruction  output  DW    PC delta of the last taken branch
//  br_taken           output  1     one-cycle pulse: delta_instruction valid
//  global_disable     output  1     flush window; fetch/decode squash
//  flags              output  4     {N,Z,C,V}
//  dbg_sel            input   RW    debug read select
//  dbg_data           output  DW    R[dbg_sel], combinational
// BEHAVIOUR
//  Reset: all R[i]=0, flags=0, delta_instruction=0, br_taken=0, global_disable=0, MUL idle, in_ready=1.
//  Accept = in_valid & in_ready. Single-cycle ops write R[sel_in] at the accepting edge (visible next cycle).
//  MOV: R[sel_in]=rhs (sel_p0 ignored when num_to_rhs=1; MOV reg uses R[sel_p0]). ADD/SUB/AND/ORR/EOR: R[sel_in]=R[sel_p0] op rhs.
//  Arithmetic wraps mod 2^DW. Only CMP updates flags; it writes no register.
//  CMP flags: N=res[DW-1], Z=(res==0), C=(p0>=rhs unsigned), V=signed overflow of p0-rhs.
//  B: cond from flags at the accept edge (EQ..LE per ARM, AL=1110/1111).
//   Taken: delta_instruction<=num, br_taken=1 next cycle, global_disable=1 for FLUSH_CYCLES cycles.
//   Not taken: no output change.
//  During global_disable: in_ready=1, accepted uops are discarded (no reg/flag write, no branch). Counter is never retriggered.
//  Undefined uop codes (10..31) behave as NOP.
//  Same-cycle read/write of one register: reads return the pre-edge value. No internal forwarding; single-issue.
// CONFIGURATION
//  EXEC_MUL_EN defined: MUL is a DW-cycle shift-add.
//   in_ready=0 from the accept edge until R[sel_in]=low DW bits of R[sel_p0]*rhs is written at cycle DW.
//   Operands and sel_in are latched at accept. rst_n low mid-MUL aborts; no write.
//  EXEC_MUL_EN undefined: uop 9 is a NOP and in_ready is tied 1.
// STRUCTURE
//  exec_pkg: uop localparams, cond-code localparams, flag bit indices, cond_eval function.
//  Sub-module exec_mul_iter (start/busy/done, DW param), instantiated only under EXEC_MUL_EN.
// TESTING
//  1 MOV #0xCAFE->r1, MOV #0xDEAD->r2, ADD r1,r2->r4 -> dbg r4=0x1A9AB, flags unchanged 0.
//  2 MOV #1->r6,r7; CMP r6,r7 -> flags=4'b0110 (Z,C). MOV #0->r6; CMP r6,r7 -> N=1,C=0 (4'b1000).
//  3 After test 2, B cond=EQ(0000) num=8 -> no br_taken. B cond=NE num=0x10 -> br_taken 1 cycle, delta=0x10.
//    global_disable high for 2 cycles; MOV #5->r3 issued in that window leaves r3 unchanged.
//  4 Overflow: MOV #0xFFFFFFFF->r1, ADD r1,#1->r2 -> r2=0. CMP 0x7FFFFFFF,#0xFFFFFFFF -> V=1.
//  5 EXEC_MUL_EN: MUL r1(=7)*#6->r5 -> in_ready low 32 cycles, r5=42. Repeat with rst_n low at cycle 10 -> r5=0, in_ready=1.
//  6 in_valid=0 for 5 cycles with garbage inputs -> no reg/flag change; uop 31 -> NOP.

Source files
------------

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// exec_pkg : shared encodings for the execute stage and the ARM condition
//            evaluator used for conditional branches.
// Rev 1.0
// ============================================================================
package exec_pkg;

    localparam logic [4:0] c_uop_nop = 5'd0;
    localparam logic [4:0] c_uop_add = 5'd1;
    localparam logic [4:0] c_uop_sub = 5'd2;
    localparam logic [4:0] c_uop_and = 5'd3;
    localparam logic [4:0] c_uop_orr = 5'd4;
    localparam logic [4:0] c_uop_cmp = 5'd5;
    localparam logic [4:0] c_uop_eor = 5'd6;
    localparam logic [4:0] c_uop_b   = 5'd7;
    localparam logic [4:0] c_uop_mov = 5'd8;
    localparam logic [4:0] c_uop_mul = 5'd9;

    localparam logic [3:0] c_cond_eq = 4'b0000;
    localparam logic [3:0] c_cond_ne = 4'b0001;
    localparam logic [3:0] c_cond_cs = 4'b0010;
    localparam logic [3:0] c_cond_cc = 4'b0011;
    localparam logic [3:0] c_cond_mi = 4'b0100;
    localparam logic [3:0] c_cond_pl = 4'b0101;
    localparam logic [3:0] c_cond_vs = 4'b0110;
    localparam logic [3:0] c_cond_vc = 4'b0111;
    localparam logic [3:0] c_cond_hi = 4'b1000;
    localparam logic [3:0] c_cond_ls = 4'b1001;
    localparam logic [3:0] c_cond_ge = 4'b1010;
    localparam logic [3:0] c_cond_lt = 4'b1011;
    localparam logic [3:0] c_cond_gt = 4'b1100;
    localparam logic [3:0] c_cond_le = 4'b1101;
    localparam logic [3:0] c_cond_al = 4'b1110;
    localparam logic [3:0] c_cond_nv = 4'b1111;

    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    // 4'b1111 is architecturally "never" on old cores; this core treats it as always
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[c_flag_n];
        z = f[c_flag_z];
        c = f[c_flag_c];
        v = f[c_flag_v];
        case (cond)
            c_cond_eq: cond_eval = z;
            c_cond_ne: cond_eval = ~z;
            c_cond_cs: cond_eval = c;
            c_cond_cc: cond_eval = ~c;
            c_cond_mi: cond_eval = n;
            c_cond_pl: cond_eval = ~n;
            c_cond_vs: cond_eval = v;
            c_cond_vc: cond_eval = ~v;
            c_cond_hi: cond_eval = c & ~z;
            c_cond_ls: cond_eval = ~c | z;
            c_cond_ge: cond_eval = (n == v);
            c_cond_lt: cond_eval = (n != v);
            c_cond_gt: cond_eval = ~z & (n == v);
            c_cond_le: cond_eval = z | (n != v);
            default:   cond_eval = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_mul_iter.sv
`default_nettype none
// ============================================================================
// exec_mul_iter : iterative shift-add multiplier, one multiplier bit per cycle,
//                 DW cycles per product (low DW bits only).
// Rev 1.0
// ============================================================================
module exec_mul_iter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result
);
    localparam int c_cw = $clog2(DW);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_mcand;
    logic [DW-1:0]   r_mplier;
    logic [DW-1:0]   r_acc;
    logic [c_cw-1:0] r_cnt;
    logic [DW-1:0]   w_acc_next;
    logic            w_last;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == c_cw'(DW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        result       = w_acc_next;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    done         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The final iteration's sum goes straight out as result, saving a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_mcand  <= op_a;
                r_mplier <= op_b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end
        end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_pipe.sv
`default_nettype none
// ============================================================================
// exec_pipe : execute stage - register file, ALU, NZCV flags, conditional
//             branch resolution with a fetch/decode flush window.
//             Optional iterative MUL when EXEC_MUL_EN is defined.
// Rev 1.0
// ============================================================================
module exec_pipe
    import exec_pkg::*;
#(
    parameter int  DW           = 32,
    parameter int  NREGS        = 16,
    parameter int  FLUSH_CYCLES = 2,
    localparam int RW           = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    uop,
    input  logic          num_to_rhs,
    input  logic [DW-1:0] num,
    input  logic [RW-1:0] sel_p0,
    input  logic [RW-1:0] sel_p1,
    input  logic [RW-1:0] sel_in,
    input  logic [3:0]    branch_cond,
    output logic [DW-1:0] delta_instruction,
    output logic          br_taken,
    output logic          global_disable,
    output logic [3:0]    flags,
    input  logic [RW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data
);
    localparam int c_fw = $clog2(FLUSH_CYCLES + 1);

    logic [DW-1:0]   r_regs [NREGS];
    logic [3:0]      r_flags;
    logic [DW-1:0]   r_delta;
    logic            r_br_taken;
    logic [c_fw-1:0] r_flush_cnt;

    logic [DW-1:0]   w_p0;
    logic [DW-1:0]   w_p1;
    logic [DW-1:0]   w_rhs;
    logic [DW-1:0]   w_sub;
    logic [3:0]      w_flags_next;
    logic            w_live;
    logic            w_we;
    logic [RW-1:0]   w_wsel;
    logic [DW-1:0]   w_wdata;
    logic            w_flags_we;
    logic            w_take;
    logic            w_mul_done;
    logic [DW-1:0]   w_mul_result;
    logic [RW-1:0]   w_mul_dst;
`ifdef EXEC_MUL_EN
    logic            w_mul_start;
    logic            w_mul_busy;
    logic [RW-1:0]   r_mul_dst;
`endif

    assign w_p0  = r_regs[sel_p0];
    assign w_p1  = r_regs[sel_p1];
    assign w_rhs = num_to_rhs ? num : w_p1;
    assign w_sub = w_p0 - w_rhs;

    assign w_flags_next[c_flag_n] = w_sub[DW-1];
    assign w_flags_next[c_flag_z] = (w_sub == '0);
    assign w_flags_next[c_flag_c] = (w_p0 >= w_rhs);
    assign w_flags_next[c_flag_v] = (w_p0[DW-1] ^ w_rhs[DW-1]) & (w_sub[DW-1] ^ w_p0[DW-1]);

    // Uops accepted inside the flush window are swallowed without effect
    assign w_live = in_valid & in_ready & ~global_disable;

    always_comb begin
        w_we       = 1'b0;
        w_wsel     = sel_in;
        w_wdata    = '0;
        w_flags_we = 1'b0;
        w_take     = 1'b0;
`ifdef EXEC_MUL_EN
        w_mul_start = 1'b0;
`endif
        if (w_live) begin
            case (uop)
                c_uop_add: begin w_we = 1'b1; w_wdata = w_p0 + w_rhs; end
                c_uop_sub: begin w_we = 1'b1; w_wdata = w_sub;        end
                c_uop_and: begin w_we = 1'b1; w_wdata = w_p0 & w_rhs; end
                c_uop_orr: begin w_we = 1'b1; w_wdata = w_p0 | w_rhs; end
                c_uop_eor: begin w_we = 1'b1; w_wdata = w_p0 ^ w_rhs; end
                c_uop_mov: begin w_we = 1'b1; w_wdata = num_to_rhs ? num : w_p0; end
                c_uop_cmp: w_flags_we = 1'b1;
                c_uop_b:   w_take = cond_eval(branch_cond, r_flags);
`ifdef EXEC_MUL_EN
                c_uop_mul: w_mul_start = 1'b1;
`endif
                default: ;
            endcase
        end
        if (w_mul_done) begin
            w_we    = 1'b1;
            w_wsel  = w_mul_dst;
            w_wdata = w_mul_result;
        end
    end

`ifdef EXEC_MUL_EN
    exec_mul_iter #(
        .DW(DW)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_mul_start),
        .op_a   (w_p0),
        .op_b   (w_rhs),
        .busy   (w_mul_busy),
        .done   (w_mul_done),
        .result (w_mul_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_dst <= '0;
        end else if (w_mul_start) begin
            r_mul_dst <= sel_in;
        end
    end

    assign w_mul_dst = r_mul_dst;
    assign in_ready  = ~w_mul_busy;
`else
    assign w_mul_done   = 1'b0;
    assign w_mul_result = '0;
    assign w_mul_dst    = '0;
    assign in_ready     = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_wsel] <= w_wdata;
        end
    end

    // A taken branch can only be seen with the counter at zero, so no retrigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags     <= '0;
            r_delta     <= '0;
            r_br_taken  <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_br_taken <= w_take;
            if (w_flags_we) begin
                r_flags <= w_flags_next;
            end
            if (w_take) begin
                r_delta     <= num;
                r_flush_cnt <= c_fw'(FLUSH_CYCLES);
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

    assign delta_instruction = r_delta;
    assign br_taken          = r_br_taken;
    assign global_disable    = (r_flush_cnt != '0);
    assign flags             = r_flags;
    assign dbg_data          = r_regs[dbg_sel];

endmodule
`default_nettype wire
